// File: rtl/lsu_mmio.sv
// lsu_mmio: valid/ready load/store unit with data RAM, output peripheral registers and a switch port.
// Optional LSU_HEX_DECODE_EN: HEX registers hold a nibble and drive io_hex_o through a 7-segment decoder.
module lsu_mmio #(
  parameter int                ADDR_W     = 12,
  parameter int                DMEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] OUT_BASE   = ADDR_W'(12'h700),
  parameter logic [ADDR_W-1:0] IN_BASE    = ADDR_W'(12'h800),
  parameter int                NUM_HEX    = 8,
  parameter int                LEDR_W     = 17,
  parameter int                LEDG_W     = 8,
  parameter int                LCD_W      = 11,
  parameter int                SW_W       = 18
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [2:0]              req_op_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [31:0]             resp_rdata_o,
  output logic                    resp_err_o,
  input  logic [SW_W-1:0]         sw_i,
  output logic [NUM_HEX-1:0][6:0] io_hex_o,
  output logic [LEDR_W-1:0]       io_ledr_o,
  output logic [LEDG_W-1:0]       io_ledg_o,
  output logic [LCD_W-1:0]        io_lcd_o
);

  localparam int DM_AW    = $clog2(DMEM_WORDS);
  localparam int NUM_OUT  = NUM_HEX + 3;
  localparam int LEDR_IDX = NUM_HEX;
  localparam int LEDG_IDX = NUM_HEX + 1;
  localparam int LCD_IDX  = NUM_HEX + 2;
`ifdef LSU_HEX_DECODE_EN
  localparam int HEX_W = 4;
`else
  localparam int HEX_W = 7;
`endif
  localparam int FLD_A = (HEX_W > LEDR_W) ? HEX_W : LEDR_W;
  localparam int FLD_B = (LEDG_W > LCD_W) ? LEDG_W : LCD_W;
  localparam int FLD_W = (FLD_A > FLD_B) ? FLD_A : FLD_B;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                      state_reg, state_next;
  logic [SW_W-1:0]             sw_meta_reg, sw_sync_reg;
  logic [NUM_HEX-1:0][HEX_W-1:0] hex_reg;
  logic [LEDR_W-1:0]           ledr_reg;
  logic [LEDG_W-1:0]           ledg_reg;
  logic [LCD_W-1:0]            lcd_reg;
  logic [31:0]                 dmem [DMEM_WORDS];
  logic [31:0]                 dmem_q_reg, per_q_reg;
  logic                        resp_err_reg, resp_we_reg, resp_dmem_reg;
  logic [2:0]                  resp_op_reg;
  logic [1:0]                  resp_lane_reg;

  logic [1:0]        size;
  logic [ADDR_W-1:0] out_off, out_k;
  logic              dmem_hit, out_hit, in_hit, misalign, bad, accept, do_store;
  logic [3:0]        be;
  logic [31:0]       wdata_lane, bmask, per_rd;
  logic [FLD_W-1:0]  per_merged;
  logic [DM_AW-1:0]  dm_idx;
  logic [31:0]       load_word, lane_word, load_ext;

  // Request decode: region, alignment, lane enables and right-aligned store data replicated across lanes.
  always_comb begin
    size     = req_op_i[1:0];
    out_off  = req_addr_i - OUT_BASE;
    out_k    = out_off >> 2;
    dmem_hit = 32'(req_addr_i) < 32'(4 * DMEM_WORDS);
    out_hit  = (req_addr_i >= OUT_BASE) && (32'(out_off) < 32'(4 * NUM_OUT));
    in_hit   = req_addr_i[ADDR_W-1:2] == IN_BASE[ADDR_W-1:2];
    misalign = (size == 2'b01 && req_addr_i[0]) ||
               (size == 2'b10 && req_addr_i[1:0] != 2'b00);
    bad      = (size == 2'b11) || misalign || !(dmem_hit || out_hit || in_hit) ||
               (req_we_i && in_hit);
    accept   = req_valid_i && (state_reg == IDLE);
    do_store = accept && req_we_i && !bad;
    dm_idx   = req_addr_i[DM_AW+1:2];
    case (size)
      2'b00: begin
        be         = 4'b0001 << req_addr_i[1:0];
        wdata_lane = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be         = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = req_wdata_i;
      end
    endcase
    bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  always_comb begin
    per_rd = '0;
    for (int k = 0; k < NUM_HEX; k++)
      if (out_k == ADDR_W'(k)) per_rd = 32'(hex_reg[k]);
    if (out_k == ADDR_W'(LEDR_IDX)) per_rd = 32'(ledr_reg);
    if (out_k == ADDR_W'(LEDG_IDX)) per_rd = 32'(ledg_reg);
    if (out_k == ADDR_W'(LCD_IDX))  per_rd = 32'(lcd_reg);
    if (in_hit) per_rd = 32'(sw_sync_reg);
    per_merged = FLD_W'((per_rd & ~bmask) | (wdata_lane & bmask));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw_i;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // Read port samples the old word; stores go through per-byte enables so untouched lanes keep their data.
  always_ff @(posedge clk_i) begin
    if (accept) dmem_q_reg <= dmem[dm_idx];
    for (int b = 0; b < 4; b++)
      if (do_store && dmem_hit && be[b]) dmem[dm_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hex_reg  <= '0;
      ledr_reg <= '0;
      ledg_reg <= '0;
      lcd_reg  <= '0;
    end else if (do_store && out_hit) begin
      for (int k = 0; k < NUM_HEX; k++)
        if (out_k == ADDR_W'(k)) hex_reg[k] <= per_merged[HEX_W-1:0];
      if (out_k == ADDR_W'(LEDR_IDX)) ledr_reg <= per_merged[LEDR_W-1:0];
      if (out_k == ADDR_W'(LEDG_IDX)) ledg_reg <= per_merged[LEDG_W-1:0];
      if (out_k == ADDR_W'(LCD_IDX))  lcd_reg  <= per_merged[LCD_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_err_reg  <= 1'b0;
      resp_we_reg   <= 1'b0;
      resp_dmem_reg <= 1'b0;
      resp_op_reg   <= '0;
      resp_lane_reg <= '0;
      per_q_reg     <= '0;
    end else if (accept) begin
      resp_err_reg  <= bad;
      resp_we_reg   <= req_we_i;
      resp_dmem_reg <= dmem_hit;
      resp_op_reg   <= req_op_i;
      resp_lane_reg <= req_addr_i[1:0];
      per_q_reg     <= per_rd;
    end
  end

  // Response fields come only from registers captured at acceptance, so they stay put while stalled.
  always_comb begin
    load_word = resp_dmem_reg ? dmem_q_reg : per_q_reg;
    lane_word = load_word >> {resp_lane_reg, 3'b000};
    case (resp_op_reg[1:0])
      2'b00:   load_ext = resp_op_reg[2] ? {24'b0, lane_word[7:0]} :
                                           {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_ext = resp_op_reg[2] ? {16'b0, lane_word[15:0]} :
                                           {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_ext = lane_word;
    endcase
    resp_rdata_o = (resp_valid_o && !resp_err_reg && !resp_we_reg) ? load_ext : '0;
    resp_err_o   = resp_valid_o && resp_err_reg;
  end

`ifdef LSU_HEX_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HEX; gi++) begin : g_hex
`ifdef LSU_HEX_DECODE_EN
      assign io_hex_o[gi] = seg7(hex_reg[gi]);
`else
      assign io_hex_o[gi] = hex_reg[gi];
`endif
    end
  endgenerate

  assign io_ledr_o = ledr_reg;
  assign io_ledg_o = ledg_reg;
  assign io_lcd_o  = lcd_reg;

endmodule

// File: tb/tb_lsu_mmio.sv
// Randomised bench for lsu_mmio against a byte-level memory / register reference model.
module tb_lsu_mmio;
  localparam int ADDR_W = 12, DMEM_WORDS = 256, NUM_HEX = 8;
  localparam int LEDR_W = 17, LEDG_W = 8, LCD_W = 11, SW_W = 18;
  localparam logic [11:0] OUT_BASE = 12'h700, IN_BASE = 12'h800;
`ifdef LSU_HEX_DECODE_EN
  localparam int HEX_W = 4;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`else
  localparam int HEX_W = 7;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_op = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic [SW_W-1:0] sw = 18'h12345;
  logic [NUM_HEX-1:0][6:0] io_hex;
  logic [LEDR_W-1:0] io_ledr;
  logic [LEDG_W-1:0] io_ledg;
  logic [LCD_W-1:0] io_lcd;

  lsu_mmio dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .sw_i(sw), .io_hex_o(io_hex), .io_ledr_o(io_ledr), .io_ledg_o(io_ledg), .io_lcd_o(io_lcd)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: byte-addressed data memory, masked peripheral fields, and switch value two edges old.
  logic [7:0]  m_mem [0:4*DMEM_WORDS-1];
  logic [31:0] m_per [0:NUM_HEX+2];
  logic [SW_W-1:0] sw_d1 = '0, sw_d2 = '0;

  always @(posedge clk) begin
    if (rst) begin
      sw_d1 <= '0;
      sw_d2 <= '0;
    end else begin
      sw_d1 <= sw;
      sw_d2 <= sw_d1;
    end
  end

  function automatic logic [31:0] fld_mask(input int k);
    int w;
    if (k < NUM_HEX) w = HEX_W;
    else if (k == NUM_HEX) w = LEDR_W;
    else if (k == NUM_HEX + 1) w = LEDG_W;
    else w = LCD_W;
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  task automatic model(input bit we, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int a, nb, base, off, k;
    bit is_dm, is_out, is_in;
    logic [31:0] w, v;
    a = int'(addr);
    nb = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    base = a & ~3;
    off = a & 3;
    k = (base - int'(OUT_BASE)) / 4;
    is_dm = a < 4 * DMEM_WORDS;
    is_out = a >= int'(OUT_BASE) && a < int'(OUT_BASE) + 4 * (NUM_HEX + 3);
    is_in = base == int'(IN_BASE);
    err = (op[1:0] == 2'd3) || (a % nb != 0) || !(is_dm || is_out || is_in) || (we && is_in);
    rdata = '0;
    if (err) return;
    if (is_dm) w = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    else if (is_out) w = m_per[k];
    else w = 32'(sw_d2);
    if (we) begin
      for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      if (is_dm) for (int i = 0; i < 4; i++) m_mem[base+i] = w[8*i +: 8];
      else m_per[k] = w & fld_mask(k);
    end else begin
      v = w >> (8 * off);
      if (nb == 1) rdata = op[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      else if (nb == 2) rdata = op[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else rdata = v;
    end
  endtask

  task automatic check_io(input string tag);
    logic [6:0] e;
    for (int k = 0; k < NUM_HEX; k++) begin
`ifdef LSU_HEX_DECODE_EN
      e = seg_tab[m_per[k][3:0]];
`else
      e = m_per[k][6:0];
`endif
      check_val($sformatf("%s/hex%0d", tag, k), 32'(io_hex[k]), 32'(e));
    end
    check_val({tag, "/ledr"}, 32'(io_ledr), m_per[NUM_HEX]);
    check_val({tag, "/ledg"}, 32'(io_ledg), m_per[NUM_HEX+1]);
    check_val({tag, "/lcd"}, 32'(io_lcd), m_per[NUM_HEX+2]);
  endtask

  task automatic do_req(input string tag, input bit we, input logic [2:0] op,
                        input logic [11:0] addr, input logic [31:0] wdata, input int stall,
                        input bit chk_data, output logic [31:0] got, output logic got_err);
    logic e_err;
    logic [31:0] e_dat;
    @(negedge clk);
    model(we, op, addr, wdata, e_err, e_dat);
    check_val({tag, "/rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = resp_rdata;
    got_err = resp_err;
    check_val({tag, "/vld"}, 32'(resp_valid), 32'd1);
    check_val({tag, "/err"}, 32'(resp_err), 32'(e_err));
    if (chk_data) check_val({tag, "/data"}, resp_rdata, e_dat);
    check_io(tag);
    repeat (stall) begin
      @(negedge clk);
      check_val({tag, "/hold_err"}, 32'(resp_err), 32'(e_err));
      if (chk_data) check_val({tag, "/hold_data"}, resp_rdata, e_dat);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val({tag, "/retired"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] g, e_dat;
    logic ge, e_err;
    logic [11:0] a;
    int r;
    for (int k = 0; k < NUM_HEX + 3; k++) m_per[k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst/resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst/resp_err", 32'(resp_err), 32'd0);
    check_val("rst/resp_rdata", resp_rdata, 32'd0);
    check_val("rst/req_ready", 32'(req_ready), 32'd1);
    check_io("rst");
    rst = 1'b0;

    do_req("lw0", 0, 3'b010, 12'h000, 32'd0, 0, 0, g, ge);

    for (int w = 0; w < DMEM_WORDS; w++)
      do_req("fill", 1, 3'b010, 12'(4 * w), $urandom, 0, 1, g, ge);

    do_req("sw10", 1, 3'b010, 12'h010, 32'h80FF_1234, 0, 1, g, ge);
    do_req("sb11", 1, 3'b000, 12'h011, 32'h0000_00AA, 0, 1, g, ge);
    do_req("lw10", 0, 3'b010, 12'h010, 32'd0, 0, 1, g, ge);
    check_val("lw10_const", g, 32'h80FF_AA34);
    do_req("lb13", 0, 3'b000, 12'h013, 32'd0, 0, 1, g, ge);
    check_val("lb13_const", g, 32'hFFFF_FF80);
    do_req("lbu13", 0, 3'b100, 12'h013, 32'd0, 1, 1, g, ge);
    check_val("lbu13_const", g, 32'h0000_0080);
    do_req("lhu12", 0, 3'b101, 12'h012, 32'd0, 0, 1, g, ge);
    check_val("lhu12_const", g, 32'h0000_80FF);

    do_req("lh11", 0, 3'b001, 12'h011, 32'd0, 0, 1, g, ge);
    check_val("lh11_err", 32'(ge), 32'd1);
    do_req("sw12", 1, 3'b010, 12'h012, 32'hDEAD_BEEF, 0, 1, g, ge);
    check_val("sw12_err", 32'(ge), 32'd1);
    do_req("lw10b", 0, 3'b010, 12'h010, 32'd0, 0, 1, g, ge);
    check_val("lw10b_const", g, 32'h80FF_AA34);
    do_req("lw900", 0, 3'b010, 12'h900, 32'd0, 0, 1, g, ge);
    check_val("lw900_err", 32'(ge), 32'd1);

    do_req("sw_ledr", 1, 3'b010, OUT_BASE + 12'h20, 32'hFFFF_FFFF, 0, 1, g, ge);
    check_val("ledr_const", 32'(io_ledr), 32'h0001_FFFF);
    do_req("lw_ledr", 0, 3'b010, OUT_BASE + 12'h20, 32'd0, 0, 1, g, ge);
    check_val("lw_ledr_const", g, 32'h0001_FFFF);
    do_req("sw_in", 1, 3'b010, IN_BASE, 32'h1234_5678, 0, 1, g, ge);
    check_val("sw_in_err", 32'(ge), 32'd1);

    // New switch value must not be visible to a read accepted only one edge later.
    @(negedge clk);
    sw = 18'h2A5A5;
    do_req("sw_old", 0, 3'b010, IN_BASE, 32'd0, 0, 1, g, ge);
    check_val("sw_old_const", g, 32'h0001_2345);
    do_req("sw_new", 0, 3'b010, IN_BASE, 32'd0, 0, 1, g, ge);
    check_val("sw_new_const", g, 32'h0002_A5A5);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
      r = $urandom_range(0, 9);
      if (r < 5) a = 12'($urandom_range(0, 4 * DMEM_WORDS - 1));
      else if (r < 7) a = 12'(int'(OUT_BASE) + $urandom_range(0, 47));
      else if (r == 7) a = 12'(int'(IN_BASE) + $urandom_range(0, 7));
      else if (r == 8) a = 12'($urandom);
      else a = 12'h900;
      do_req($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom), a, $urandom,
             $urandom_range(0, 2), 1, g, ge);
    end

    // Response must hold while a second request waits, and that request must not sneak in at retirement.
    @(negedge clk);
    model(1'b0, 3'b010, 12'h010, 32'd0, e_err, e_dat);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 12'h010;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'h5555_5555;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("stall/vld", 32'(resp_valid), 32'd1);
      check_val("stall/rdy", 32'(req_ready), 32'd0);
      check_val("stall/data", resp_rdata, e_dat);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val("stall/retired", 32'(resp_valid), 32'd0);
    check_val("stall/idle_rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    do_req("stall_chk", 0, 3'b010, 12'h020, 32'd0, 0, 1, g, ge);

    do_req("pre_rst_ledr", 1, 3'b010, OUT_BASE + 12'h20, 32'h0000_1234, 0, 1, g, ge);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = OUT_BASE + 12'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("rst2/pre_vld", 32'(resp_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst2/vld", 32'(resp_valid), 32'd0);
    check_val("rst2/err", 32'(resp_err), 32'd0);
    check_val("rst2/data", resp_rdata, 32'd0);
    for (int k = 0; k < NUM_HEX + 3; k++) m_per[k] = '0;
    check_io("rst2");
    @(negedge clk);
    rst = 1'b0;
    do_req("post_rst", 0, 3'b010, OUT_BASE + 12'h20, 32'd0, 0, 1, g, ge);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
